alu_issue_ctrl: RTL

Initiator side of the 16-bit ALU interface. Accepts operation requests over a valid/ready handshake and holds them in an issue register that drives the combinational ALU's Operation/Operand ports. Captures the ALU's Result/Flags into an in-order response FIFO and maintains the architectural flags register. Evaluates branch condition codes against that register for the decode/branch logic.

---
 rtl/micropop_pkg.sv | 32 +++
 rtl/alu_issue_ctrl_resp_fifo.sv | 70 +++++++
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/micropop_pkg.sv
// Shared types for the ALU issue path: opcodes, flag bit positions and
// branch condition selectors.
package micropop_pkg;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      SHL = 3'd2,
      SHR = 3'd3,
      SRA = 3'd4,
      AND = 3'd5,
      OR  = 3'd6,
      XOR = 3'd7
   } alu_op_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_C = 3;

   typedef enum logic [2:0] {
      AL = 3'd0,
      EQ = 3'd1,
      NE = 3'd2,
      LT = 3'd3,
      GE = 3'd4,
      CS = 3'd5,
      CC = 3'd6,
      MI = 3'd7
   } cond_t;

endpackage

// File: rtl/alu_issue_ctrl_resp_fifo.sv
// In-order response FIFO with synchronous flush and asynchronous reset.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module resp_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  data_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; the head is masked while empty, so stale data never shows.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue register in front of a combinational ALU, response FIFO behind it,
// plus the architectural flags register and branch condition evaluation.
module alu_issue_ctrl
   import micropop_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   parameter int TAGW  = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Flush,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  alu_op_t          ReqOperation,
   input  logic [WIDTH-1:0] ReqOperand1,
   input  logic [WIDTH-1:0] ReqOperand2,
   input  logic [TAGW-1:0]  ReqTag,
   input  logic             ReqSetFlags,
   output alu_op_t          AluOperation,
   output logic [WIDTH-1:0] AluOperand1,
   output logic [WIDTH-1:0] AluOperand2,
   input  logic [WIDTH-1:0] AluResult,
   input  logic [3:0]       AluFlags,
   output logic             RspValid,
   input  logic             RspReady,
   output logic [WIDTH-1:0] RspResult,
   output logic [3:0]       RspFlags,
   output logic [TAGW-1:0]  RspTag,
   output logic [3:0]       FlagsReg,
   input  cond_t            CondCode,
   output logic             CondTrue
);

   localparam int EW = WIDTH + 4 + TAGW;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      alu_op_t          op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAGW-1:0]  tag;
      logic             set_flags;
   } issue_t;

   issue_t        issue_q, issue_d;
   logic          issue_valid_q, issue_valid_d;
   logic [3:0]    flags_q, flags_d;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic [EW-1:0] fifo_head;
   logic          pop, retire, accept;

   assign RspValid = !fifo_empty;
   assign pop      = RspValid && RspReady;
   assign retire   = issue_valid_q && ((fifo_count < CW'(DEPTH)) || pop);
   // RspReady reaches ReqReady combinationally so a full FIFO can drain and refill in one edge.
   assign ReqReady = !Reset && (!issue_valid_q || retire);
   assign accept   = ReqValid && ReqReady;

   // NOTE: every always_comb output gets a default first, which rules out inferred latches.
   always_comb begin
      issue_d       = issue_q;
      issue_valid_d = issue_valid_q;
      flags_d       = flags_q;
      if (Flush) begin
         issue_valid_d = 1'b0;
      end else begin
         if (retire) begin
            issue_valid_d = 1'b0;
            if (issue_q.set_flags) flags_d = AluFlags;
         end
         if (accept) begin
            issue_d = '{op: ReqOperation, a: ReqOperand1, b: ReqOperand2,
                        tag: ReqTag, set_flags: ReqSetFlags};
            issue_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         issue_q       <= '0;
         issue_valid_q <= 1'b0;
         flags_q       <= '0;
      end else begin
         issue_q       <= issue_d;
         issue_valid_q <= issue_valid_d;
         flags_q       <= flags_d;
      end
   end

   resp_fifo #(.W(EW), .DEPTH(DEPTH)) u_resp_fifo (
      .clk_i   (Clock),
      .rst_i   (Reset),
      .flush_i (Flush),
      .push_i  (retire),
      .pop_i   (pop),
      .data_i  ({AluResult, AluFlags, issue_q.tag}),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign {RspResult, RspFlags, RspTag} = fifo_head;
   assign AluOperation = issue_q.op;
   assign AluOperand1  = issue_q.a;
   assign AluOperand2  = issue_q.b;
   assign FlagsReg     = flags_q;

   always_comb begin
      CondTrue = 1'b1;
      unique case (CondCode)
         AL: CondTrue = 1'b1;
         EQ: CondTrue = flags_q[FLAG_Z];
         NE: CondTrue = !flags_q[FLAG_Z];
         LT: CondTrue = flags_q[FLAG_N] ^ flags_q[FLAG_V];
         GE: CondTrue = !(flags_q[FLAG_N] ^ flags_q[FLAG_V]);
         CS: CondTrue = flags_q[FLAG_C];
         CC: CondTrue = !flags_q[FLAG_C];
         MI: CondTrue = flags_q[FLAG_N];
         default: CondTrue = 1'b1;
      endcase
   end

endmodule
